vend_output_scheduler: RTL and testbench
========================================

// Module: vend_output_scheduler
// PURPOSE
//  Sequences the vending machine's shared output actuators after payment completes.
//  Takes one accepted order (one-hot product slot plus change count), drives that
//  slot's dispense motor for a timed pulse, then returns change as timed coin pulses.
//  Tracks per-slot stock. Sits between the payment/change FSM and the output pins.
// PARAMETERS
//  PULSE_CYC   10  cycles each motor/coin pulse is held high (>=1)
//  GAP_CYC     2   idle cycles after every pulse, before the next pulse or done (>=1)
//  STOCK_INIT  3   units loaded per slot at reset/restock (1..15)
//  CHG_W       3   width of change_units (max coins = 2**CHG_W-1)
// PORTS
//  clock         in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-high; clears all state
//  vend_req      in   1      1-cycle order strobe from payment FSM
//  vend_sel      in   4      one-hot product slot, sampled with vend_req
//  change_units  in   CHG_W  coins to return, sampled with vend_req
//  restock       in   1      reload all slots to STOCK_INIT (honoured in IDLE only)
//  busy          out  1      high in every state except IDLE
//  motor         out  4      one-hot dispense motor drive
//  coin_out      out  1      change-coin ejector drive
//  done          out  1      1-cycle pulse when an order has fully completed
//  sold_out      out  1      1-cycle pulse: accepted slot had zero stock
//  err           out  1      1-cycle pulse: vend_req with non-one-hot vend_sel
//  stock_empty   out  4      per-slot flag, stock==0
// BEHAVIOUR
//  Reset: all outputs 0 except stock_empty=0; stock[i]=STOCK_INIT; state IDLE.
//  Reset mid-order aborts immediately: motor/coin_out drop asynchronously, no done.
//  States: IDLE, DISP_ON, DISP_GAP, COIN_ON, COIN_GAP, DONE.
//  IDLE: vend_req & one-hot vend_sel -> latch sel/change.
//   - stock[sel]>0 -> DISP_ON; stock[sel]==0 -> sold_out pulse, go to COIN_ON if change>0, else DONE.
//   - vend_req & not one-hot (incl. 0) -> err=1 next cycle, stay IDLE.
//   - restock (no vend_req) -> all stock=STOCK_INIT next cycle.
//   - vend_req & restock in the same cycle: the order wins; restock dropped.
//  vend_req/restock while busy: ignored, no err, no queueing.
//  Latency: request sampled at edge k -> motor[sel]=1 for cycles k+1..k+PULSE_CYC.
//  DISP_ON: motor=latched sel for PULSE_CYC cycles; on exit stock[sel]-=1 (never below 0).
//  DISP_GAP: all outputs low for GAP_CYC cycles; then COIN_ON if coins>0, else DONE.
//  COIN_ON: coin_out=1 for PULSE_CYC cycles; on exit coins-=1.
//  COIN_GAP: GAP_CYC cycles low; then COIN_ON if coins>0, else DONE.
//  DONE: done=1 for one cycle, busy still 1; -> IDLE (busy=0 next cycle).
//  motor and coin_out are never high together; each output is registered, glitch-free.
//  Timer: one down-counter, width $clog2(max(PULSE_CYC,GAP_CYC)+1), reloaded on state entry.
//  change_units=0 with stock: one motor pulse only. Max change: 2**CHG_W-1 coin pulses.
// STRUCTURE
//  Shared package vend_pkg: state encoding localparams, slot count (4), one-hot check function.
//  Sub-module vend_pulse_timer: load/count/expire down-counter, reused for pulses and gaps.
//  Stock: four 4-bit registers plus decrement/reload logic in the top module.
// TESTING
//  1 vend_req, sel=0010, change=0 -> motor=0010 for 10 cycles, 2 low, done at cycle 13; stock[1] 3->2.
//  2 sel=0001, change=3 -> 10-cycle motor pulse, then 3 coin pulses of 10 cycles with 2-cycle gaps, then done.
//  3 Order slot 3 four times -> 4th: sold_out pulse, no motor, stock_empty[3]=1; restock clears the flag.
//  4 vend_req with sel=0110 or 0000 -> err for 1 cycle, busy stays 0; request while busy is ignored.
//  5 Assert reset during the 2nd coin pulse -> coin_out drops without waiting for a clock edge, stock=3, no done.
//  6 vend_req & restock in the same cycle in IDLE -> order runs, stock not reloaded.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending output scheduler.
// State codes, slot count and a one-hot check.
package vend_pkg;

  localparam int NSLOT = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISP_ON  = 3'd1;
  localparam logic [2:0] S_DISP_GAP = 3'd2;
  localparam logic [2:0] S_COIN_ON  = 3'd3;
  localparam logic [2:0] S_COIN_GAP = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  function automatic logic is_onehot(
    input logic [NSLOT-1:0] v
  );
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vend_output_scheduler_if.sv
// Order request and actuator output bundle between
// the payment FSM and the output scheduler.
interface vend_output_scheduler_if #(
  parameter int CHG_W = 3
);
  import vend_pkg::*;

  logic             vend_req;
  logic [NSLOT-1:0] vend_sel;
  logic [CHG_W-1:0] change_units;
  logic             restock;
  logic             busy;
  logic [NSLOT-1:0] motor;
  logic             coin_out;
  logic             done;
  logic             sold_out;
  logic             err;
  logic [NSLOT-1:0] stock_empty;

  modport master (
    output vend_req, vend_sel, change_units, restock,
    input  busy, motor, coin_out, done,
    input  sold_out, err, stock_empty
  );

  modport slave (
    input  vend_req, vend_sel, change_units, restock,
    output busy, motor, coin_out, done,
    output sold_out, err, stock_empty
  );

endinterface

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter shared by pulse and gap phases.
// expired is high once the count has reached zero.
module vend_pulse_timer #(
  parameter int TW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/vend_output_scheduler.sv
// Sequences dispense motor and change-coin pulses for
// one accepted order and tracks per-slot stock.
module vend_output_scheduler
  import vend_pkg::*;
#(
  parameter int PULSE_CYC  = 10,
  parameter int GAP_CYC    = 2,
  parameter int STOCK_INIT = 3,
  parameter int CHG_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  vend_output_scheduler_if.slave bus
);

  localparam int TMAX =
    (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
  localparam logic [3:0]    STOCK_LD = 4'(STOCK_INIT);

  logic [2:0]       state, state_n;
  logic [NSLOT-1:0] sel_q, sel_n;
  logic [CHG_W-1:0] coins_q, coins_n;
  logic [3:0]       stock [NSLOT];

  logic             t_load;
  logic [TW-1:0]    t_val;
  logic             expired;

  logic             sold_n, err_n;
  logic             dec, reload;
  logic             stock_hit;

  logic             busy_q, coin_q, done_q;
  logic             sold_q, err_q;
  logic [NSLOT-1:0] motor_q, empty;

  vend_pulse_timer #(
    .TW (TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .expired  (expired)
  );

  always_comb begin
    stock_hit = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (bus.vend_sel[i] && stock[i] != 4'd0)
        stock_hit = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    coins_n = coins_q;
    t_load  = 1'b0;
    t_val   = PULSE_LD;
    sold_n  = 1'b0;
    err_n   = 1'b0;
    dec     = 1'b0;
    reload  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.vend_req) begin
          if (is_onehot(bus.vend_sel)) begin
            sel_n   = bus.vend_sel;
            coins_n = bus.change_units;
            t_load  = 1'b1;
            if (stock_hit) begin
              state_n = S_DISP_ON;
            end else begin
              sold_n  = 1'b1;
              state_n = (bus.change_units != '0) ?
                        S_COIN_ON : S_DONE;
            end
          end else begin
            err_n = 1'b1;
          end
        end else if (bus.restock) begin
          reload = 1'b1;
        end
      end
      S_DISP_ON: begin
        if (expired) begin
          state_n = S_DISP_GAP;
          t_load  = 1'b1;
          t_val   = GAP_LD;
          dec     = 1'b1;
        end
      end
      S_COIN_ON: begin
        if (expired) begin
          state_n = S_COIN_GAP;
          t_load  = 1'b1;
          t_val   = GAP_LD;
          coins_n = coins_q - 1'b1;
        end
      end
      S_DISP_GAP, S_COIN_GAP: begin
        if (expired) begin
          t_load  = 1'b1;
          state_n = (coins_q != '0) ? S_COIN_ON : S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the
  // first pulse cycle lines up with the accepting edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sel_q   <= '0;
      coins_q <= '0;
      busy_q  <= 1'b0;
      motor_q <= '0;
      coin_q  <= 1'b0;
      done_q  <= 1'b0;
      sold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      coins_q <= coins_n;
      busy_q  <= (state_n != S_IDLE);
      motor_q <= (state_n == S_DISP_ON) ? sel_n : '0;
      coin_q  <= (state_n == S_COIN_ON);
      done_q  <= (state_n == S_DONE);
      sold_q  <= sold_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++)
        stock[i] <= STOCK_LD;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (reload)
          stock[i] <= STOCK_LD;
        else if (dec && sel_q[i] && stock[i] != 4'd0)
          stock[i] <= stock[i] - 4'd1;
      end
    end
  end

  always_comb begin
    empty = '0;
    for (int i = 0; i < NSLOT; i++)
      empty[i] = (stock[i] == 4'd0);
  end

  assign bus.busy        = busy_q;
  assign bus.motor       = motor_q;
  assign bus.coin_out    = coin_q;
  assign bus.done        = done_q;
  assign bus.sold_out    = sold_q;
  assign bus.err         = err_q;
  assign bus.stock_empty = empty;

endmodule

// File: tb/tb_vend_output_scheduler.sv
// Bench for vend_output_scheduler: order-timeline model
// plus directed scenarios with literal expectations.
module tb_vend_output_scheduler;

  localparam int P  = 10;
  localparam int G  = 2;
  localparam int SI = 3;
  localparam int CW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  vend_output_scheduler_if #(.CHG_W(CW)) bus ();

  vend_output_scheduler #(
    .PULSE_CYC  (P),
    .GAP_CYC    (G),
    .STOCK_INIT (SI),
    .CHG_W      (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       busy;
    logic [3:0] motor;
    logic       coin;
    logic       done;
    logic       sold;
    logic       err;
    logic       dec_v;
    logic [1:0] dec_s;
  } ent_t;

  ent_t q[$];
  ent_t cur = '0;
  int   m_stock [4];
  logic was_busy;
  int   slot;
  int   checks = 0;
  int   errors = 0;

  // Whole order timeline is expanded into per-cycle entries.
  task automatic push_order(input int s, input int chg,
                            input bit has);
    ent_t e;
    int   first;
    first = q.size();
    if (has) begin
      for (int i = 0; i < P; i++) begin
        e = '0; e.busy = 1; e.motor = 4'(1 << s);
        q.push_back(e);
      end
      for (int i = 0; i < G; i++) begin
        e = '0; e.busy = 1;
        if (i == 0) begin e.dec_v = 1; e.dec_s = 2'(s); end
        q.push_back(e);
      end
    end
    for (int c = 0; c < chg; c++) begin
      for (int i = 0; i < P; i++) begin
        e = '0; e.busy = 1; e.coin = 1; q.push_back(e);
      end
      for (int i = 0; i < G; i++) begin
        e = '0; e.busy = 1; q.push_back(e);
      end
    end
    e = '0; e.busy = 1; e.done = 1;
    q.push_back(e);
    if (!has) q[first].sold = 1'b1;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      cur = '0;
      for (int i = 0; i < 4; i++) m_stock[i] = SI;
    end else begin
      was_busy = cur.busy;
      cur = '0;
      if (was_busy) begin
        if (q.size() > 0) cur = q.pop_front();
      end else if (bus.vend_req) begin
        if ($countones(bus.vend_sel) == 1) begin
          slot = 0;
          for (int i = 0; i < 4; i++)
            if (bus.vend_sel[i]) slot = i;
          push_order(slot, int'(bus.change_units),
                     m_stock[slot] > 0);
          cur = q.pop_front();
        end else begin
          cur.err = 1'b1;
        end
      end else if (bus.restock) begin
        for (int i = 0; i < 4; i++) m_stock[i] = SI;
      end
      if (cur.dec_v && m_stock[cur.dec_s] > 0)
        m_stock[cur.dec_s]--;
    end
  end

  logic [12:0] act, expv;
  logic [3:0]  m_empty;

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) m_empty[i] = (m_stock[i] == 0);
    act  = {bus.busy, bus.motor, bus.coin_out, bus.done,
            bus.sold_out, bus.err, bus.stock_empty};
    expv = {cur.busy, cur.motor, cur.coin, cur.done,
            cur.sold, cur.err, m_empty};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL cycle_model t=%0t got=%b want=%b",
               $time, act, expv);
    end
  end

  task automatic chk(input string name, input int a,
                     input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, a, e);
    end
  endtask

  task automatic order(input logic [3:0] sel,
                       input int chg, input bit rs,
                       output int lat, output bit sold);
    bus.vend_req = 1; bus.vend_sel = sel;
    bus.change_units = CW'(chg); bus.restock = rs;
    @(negedge clock);
    bus.vend_req = 0; bus.vend_sel = 0;
    bus.change_units = 0; bus.restock = 0;
    lat = 1;
    sold = bus.sold_out;
    while (!bus.done && lat < 200) begin
      @(negedge clock);
      lat++;
      sold |= bus.sold_out;
    end
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout got=0 want=1");
    end
  endtask

  task automatic do_restock();
    bus.restock = 1;
    @(negedge clock);
    bus.restock = 0;
  endtask

  int lat;
  bit sold;
  int n;

  initial begin
    bus.vend_req = 0; bus.vend_sel = 0;
    bus.change_units = 0; bus.restock = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_motor", bus.motor, 0);
    chk("rst_empty", bus.stock_empty, 0);
    @(negedge clock);

    order(4'b0010, 0, 0, lat, sold);
    chk("t1_latency", lat, 13);
    @(negedge clock);

    order(4'b0001, 3, 0, lat, sold);
    chk("t2_latency", lat, 49);
    @(negedge clock);

    for (int k = 0; k < 3; k++) begin
      order(4'b1000, 0, 0, lat, sold);
      @(negedge clock);
    end
    chk("t3_empty", bus.stock_empty, 4'b1000);
    order(4'b1000, 0, 0, lat, sold);
    chk("t3_sold_lat", lat, 1);
    chk("t3_sold_seen", sold, 1);
    @(negedge clock);
    do_restock();
    chk("t3_restock", bus.stock_empty, 0);

    bus.vend_req = 1; bus.vend_sel = 4'b0110;
    @(negedge clock);
    bus.vend_sel = 4'b0000;
    chk("t4_err_a", bus.err, 1);
    chk("t4_busy_a", bus.busy, 0);
    @(negedge clock);
    bus.vend_req = 0;
    chk("t4_err_b", bus.err, 1);
    @(negedge clock);
    bus.vend_req = 1; bus.vend_sel = 4'b0100;
    @(negedge clock);
    bus.vend_sel = 4'b0110; bus.restock = 1;
    @(negedge clock);
    bus.vend_req = 0; bus.vend_sel = 0; bus.restock = 0;
    @(negedge clock);
    chk("t4_busy_noerr", bus.err, 0);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clock); n++;
    end
    chk("t4_done", bus.done, 1);
    @(negedge clock);

    bus.vend_req = 1; bus.vend_sel = 4'b0001;
    bus.change_units = 3;
    @(negedge clock);
    bus.vend_req = 0; bus.vend_sel = 0;
    bus.change_units = 0;
    n = 0;
    while (!bus.coin_out && n < 100) begin
      @(negedge clock); n++;
    end
    while (bus.coin_out && n < 100) begin
      @(negedge clock); n++;
    end
    while (!bus.coin_out && n < 100) begin
      @(negedge clock); n++;
    end
    repeat (3) @(negedge clock);
    chk("t5_coin_on", bus.coin_out, 1);
    #2 reset = 1;
    #1;
    chk("t5_async_coin", bus.coin_out, 0);
    chk("t5_async_busy", bus.busy, 0);
    repeat (2) @(negedge clock);
    reset = 0;
    chk("t5_done_low", bus.done, 0);
    chk("t5_empty", bus.stock_empty, 0);
    for (int k = 0; k < 2; k++) begin
      order(4'b0001, 0, 0, lat, sold);
      @(negedge clock);
    end
    chk("t5_stock_left", bus.stock_empty, 0);
    order(4'b0001, 0, 0, lat, sold);
    @(negedge clock);
    chk("t5_stock_3", bus.stock_empty, 4'b0001);

    order(4'b0001, 1, 1, lat, sold);
    chk("t6_latency", lat, 13);
    chk("t6_sold", sold, 1);
    @(negedge clock);
    chk("t6_no_reload", bus.stock_empty, 4'b0001);
    do_restock();
    chk("t6_restock", bus.stock_empty, 0);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
